bus_arbiter: RTL and testbench

//  Round-robin arbiter for the shared 4-bit tri-state data bus. Drives the E input of each

---
 rtl/bus_arbiter_pkg.sv | 10 +
 rtl/bus_arbiter_rr_pick.sv | 24 ++
 rtl/bus_arbiter.sv | 85 ++++++++
 tb/tb_bus_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared FSM state encodings and default bus widths for the bus arbiter and bus control FSM
package bus_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;
  localparam int BUS_N  = 4;
  localparam int BUS_OW = 2;
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; any=1 if a req is set, win=first set req scanning up from ptr with wrap
module rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int N  = BUS_N,
  parameter int OW = BUS_OW
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] ptr,
  output logic          any,
  output logic [OW-1:0] win
);
  // Scan offsets from highest to lowest so the smallest offset from ptr is written last and wins.
  always_comb begin
    any = 1'b0;
    win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        any = 1'b1;
        win = OW'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner arbiter driving one-hot trin enables on the shared tri-state bus
// Ports: clk, reset (sync, active-high), req[N], done[N] in; en[N] (registered one-hot-or-zero),
//        owner[OW], grant_valid (=|en), timeout (1-cycle pulse on MAX_HOLD release) out.
// Optional: define BUS_TURNAROUND_EN to insert one dead bus cycle (TURN) after every release.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N        = BUS_N,
  parameter int OW       = BUS_OW,
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  en,
  output logic [OW-1:0] owner,
  output logic          grant_valid,
  output logic          timeout
);
  state_t        state;
  logic [OW-1:0] ptr;
  logic [OW-1:0] nxt;
  logic [OW-1:0] pick_ptr;
  logic [OW-1:0] win;
  logic [CW-1:0] cnt;
  logic          any;
  logic          lim;
  logic          rel;
  assign nxt         = (owner == OW'(N - 1)) ? '0 : owner + 1'b1;
  // While granted, arbitrate as if the pointer were already advanced past the owner,
  // so a direct handover and a lone-requester regrant both fall out of one picker.
  assign pick_ptr    = (state == ST_GRANT) ? nxt : ptr;
  assign lim         = (MAX_HOLD != 0) && (cnt == CW'(MAX_HOLD - 1));
  assign rel         = !req[owner] || done[owner] || lim;
  assign grant_valid = |en;
  rr_pick #(.N(N), .OW(OW)) u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (any),
    .win (win)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      en      <= '0;
      owner   <= '0;
      ptr     <= '0;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= (state == ST_GRANT) && lim;
      case (state)
        ST_GRANT: begin
          if (rel) begin
            ptr <= nxt;
            cnt <= '0;
            en  <= '0;
`ifdef BUS_TURNAROUND_EN
            state <= ST_TURN;
`else
            state <= any ? ST_GRANT : ST_IDLE;
            if (any) begin
              en[win] <= 1'b1;
              owner   <= win;
            end
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= any ? ST_GRANT : ST_IDLE;
          en    <= '0;
          cnt   <= '0;
          if (any) begin
            en[win] <= 1'b1;
            owner   <= win;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter with a behavioural arbitration model
module tb_bus_arbiter;
  localparam int N    = 4;
  localparam int OW   = 2;
  localparam int MAXH = 8;
  localparam int CW   = 4;
  typedef struct packed {
    logic [N-1:0]  en;
    logic [OW-1:0] owner;
    logic          gv;
    logic          to;
  } exp_t;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  done = '0;
  logic [N-1:0]  en;
  logic [OW-1:0] owner;
  logic          grant_valid;
  logic          timeout;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_own = 0;
  int   m_ptr = 0;
  int   m_cnt = 0;
  bit   m_busy = 0;
  bit   m_to = 0;
  always #5 clk = ~clk;
  bus_arbiter #(.N(N), .OW(OW), .MAX_HOLD(MAXH), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .en          (en),
    .owner       (owner),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int o = 0; o < N; o++) if (r[(p + o) % N]) return (p + o) % N;
    return -1;
  endfunction
  // Behavioural model: advance one clock edge and queue the outputs expected after it.
  task automatic model(input logic rst, input logic [N-1:0] r, input logic [N-1:0] d);
    int w;
    exp_t e;
    if (rst) begin
      m_own = 0; m_ptr = 0; m_cnt = 0; m_busy = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_busy) begin
        if (!r[m_own] || d[m_own] || (m_cnt == MAXH - 1)) begin
          m_to   = (m_cnt == MAXH - 1);
          m_ptr  = (m_own + 1) % N;
          m_cnt  = 0;
          m_busy = 0;
`ifndef BUS_TURNAROUND_EN
          w = pick(r, m_ptr);
          if (w >= 0) begin
            m_busy = 1;
            m_own  = w;
          end
`endif
        end else begin
          m_cnt++;
        end
      end else begin
        w = pick(r, m_ptr);
        if (w >= 0) begin
          m_busy = 1;
          m_own  = w;
          m_cnt  = 0;
        end
      end
    end
    e.en    = m_busy ? N'(1) << m_own : '0;
    e.owner = OW'(m_own);
    e.gv    = m_busy;
    e.to    = m_to;
    sb.push_back(e);
  endtask
  task automatic step(input logic rst, input logic [N-1:0] r, input logic [N-1:0] d);
    exp_t e;
    @(negedge clk);
    reset = rst;
    req   = r;
    done  = d;
    model(rst, r, d);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("en", en, e.en);
      check("grant_valid", grant_valid, e.gv);
      check("timeout", timeout, e.to);
      if (e.gv) check("owner", owner, e.owner);
      check("onehot0", $onehot0(en), 1);
    end
  endtask
  initial begin
    int c1;
    logic [N-1:0] seq [5];
    logic [N-1:0] r;
    logic [N-1:0] d;
    step(1, 4'b1111, 4'b0000);
    step(1, 4'b1111, 4'b0000);
    check("rst_en", en, 0);
    check("rst_gv", grant_valid, 0);
    step(0, 4'b0100, 4'b0000);
    check("t2_en", en, 4'b0100);
    check("t2_owner", owner, 2);
    step(0, 4'b0000, 4'b0000);
    check("t2_drop", en, 0);
    step(1, 4'b0000, 4'b0000);
    step(0, 4'b1111, 4'b0000);
    seq[0] = en;
    for (int i = 1; i < 5; i++) begin
      step(0, 4'b1111, 4'b1111);
`ifdef BUS_TURNAROUND_EN
      check("t3_turn", en, 0);
      step(0, 4'b1111, 4'b0000);
`endif
      seq[i] = en;
    end
    for (int i = 0; i < 5; i++) check("t3_seq", seq[i], N'(1) << (i % N));
    step(1, 4'b0000, 4'b0000);
    c1 = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 4'b0011, 4'b0000);
      if (en == 4'b0001) c1++;
    end
    check("t4_hold", c1, MAXH);
    step(1, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) step(0, 4'b0010, 4'b0000);
    step(0, 4'b0010, 4'b0010);
    check("t5_regrant", en, 4'b0010);
    for (int i = 0; i < 9; i++) step(0, 4'b0010, 4'b0000);
    step(1, 4'b0000, 4'b0000);
    step(0, 4'b1000, 4'b0000);
    step(0, 4'b1000, 4'b0000);
    step(1, 4'b1000, 4'b0000);
    check("t6_rst_en", en, 0);
    step(0, 4'b1001, 4'b0000);
    check("t6_owner", owner, 0);
    for (int i = 0; i < 400; i++) begin
      r = N'($urandom);
      d = N'($urandom) & N'($urandom) & N'($urandom);
      step($urandom_range(0, 60) == 0, r, d);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
